// File: rtl/if_stage_pkg.sv
// -----------------------------------------------------------------------------
// if_stage_pkg
// Shared definitions for the instruction-fetch slice: bus widths, the zero word,
// the NOP encoding used for bubbles, the reset-active level, the fetch FSM
// state encodings and a helper that word-aligns a fetch address.
// -----------------------------------------------------------------------------
package if_stage_pkg;

  localparam int INST_ADDR_W = 32;   // InstAddrBus width
  localparam int INST_W      = 32;   // InstBus width

  localparam logic [INST_ADDR_W-1:0] ZERO_WORD  = '0;
  localparam logic [INST_W-1:0]      NOP_INST   = '0;
  localparam logic                   RST_ENABLE = 1'b1;
  localparam logic [INST_ADDR_W-1:0] PC_STEP    = 32'd4;
  localparam logic [INST_ADDR_W-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,   // presenting a request to instruction memory
    S_WAIT = 2'd1,   // request granted, waiting for rvalid
    S_HOLD = 2'd2    // response parked in the skid buffer while decode stalls
  } state_t;

  // Fetch addresses are always word aligned; the low two bits are dropped.
  function automatic logic [INST_ADDR_W-1:0] align_pc(input logic [INST_ADDR_W-1:0] pc);
    return pc & ALIGN_MASK;
  endfunction

endpackage

// File: rtl/if_stage_if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register feeding decode.
// Priority: rst > flush > stall > load > bubble.
//   flush  : clears pc, instruction and valid.
//   stall  : holds all contents.
//   load   : captures {load_pc, load_inst} as a valid instruction.
//   bubble : (no stall, no load) keeps pc, forces NOP and valid=0.
// Ports: clk, rst, stall, flush, load, load_pc[31:0], load_inst[31:0] in;
//        id_pc[31:0], id_inst[31:0], id_valid out.
// -----------------------------------------------------------------------------
module if_id_reg
  import if_stage_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall,
  input  logic                   flush,
  input  logic                   load,
  input  logic [INST_ADDR_W-1:0] load_pc,
  input  logic [INST_W-1:0]      load_inst,
  output logic [INST_ADDR_W-1:0] id_pc,
  output logic [INST_W-1:0]      id_inst,
  output logic                   id_valid
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE || flush) begin
      id_pc    <= ZERO_WORD;
      id_inst  <= NOP_INST;
      id_valid <= 1'b0;
    end else if (!stall) begin
      if (load) begin
        id_pc    <= load_pc;
        id_inst  <= load_inst;
        id_valid <= 1'b1;
      end else begin
        // Bubble: pc is left as-is so decode still sees a sensible address.
        id_inst  <= NOP_INST;
        id_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/if_stage.sv
// -----------------------------------------------------------------------------
// if_stage
// Instruction-fetch stage. Owns the PC, keeps at most one request outstanding
// to a variable-latency instruction memory, and drives the IF/ID register.
// Ports:
//   clk, rst (sync, active-high)
//   stall_i, flush_i, redirect_i, redirect_pc_i[31:0]   from pipeline control
//   imem_req_o, imem_addr_o[31:0]                        request to memory
//   imem_gnt_i, imem_rvalid_i, imem_rdata_i[31:0]        memory handshake
//   id_pc_o[31:0], id_inst_o[31:0], id_valid_o           IF/ID to decode
// -----------------------------------------------------------------------------
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   stall_i,
  input  logic                   flush_i,
  input  logic                   redirect_i,
  input  logic [INST_ADDR_W-1:0] redirect_pc_i,
  output logic                   imem_req_o,
  output logic [INST_ADDR_W-1:0] imem_addr_o,
  input  logic                   imem_gnt_i,
  input  logic                   imem_rvalid_i,
  input  logic [INST_W-1:0]      imem_rdata_i,
  output logic [INST_ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0]      id_inst_o,
  output logic                   id_valid_o
);

  state_t                 state_q, state_next;
  logic [INST_ADDR_W-1:0] pc_q, pc_next;
  logic                   kill_q, kill_next;
  logic [INST_ADDR_W-1:0] skid_pc_q, skid_pc_next;
  logic [INST_W-1:0]      skid_inst_q, skid_inst_next;

  logic                   load;
  logic [INST_ADDR_W-1:0] load_pc;
  logic [INST_W-1:0]      load_inst;
  logic [INST_ADDR_W-1:0] redirect_target;

  assign redirect_target = align_pc(redirect_pc_i);
  assign imem_addr_o     = pc_q;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC;
      kill_q      <= 1'b0;
      skid_pc_q   <= ZERO_WORD;
      skid_inst_q <= NOP_INST;
    end else begin
      state_q     <= state_next;
      pc_q        <= pc_next;
      kill_q      <= kill_next;
      skid_pc_q   <= skid_pc_next;
      skid_inst_q <= skid_inst_next;
    end
  end

  always_comb begin
    state_next     = state_q;
    pc_next        = pc_q;
    kill_next      = kill_q;
    skid_pc_next   = skid_pc_q;
    skid_inst_next = skid_inst_q;
    load           = 1'b0;
    load_pc        = pc_q;
    load_inst      = imem_rdata_i;
    imem_req_o     = 1'b0;

    case (state_q)
      S_REQ: begin
        imem_req_o = 1'b1;
        if (redirect_i) begin
          pc_next = redirect_target;
          // A grant on the old address still produces a response that
          // must be swallowed before refetching from the new target.
          if (imem_gnt_i) begin
            kill_next  = 1'b1;
            state_next = S_WAIT;
          end
        end else if (imem_gnt_i) begin
          state_next = S_WAIT;
        end
      end

      S_WAIT: begin
        if (imem_rvalid_i) begin
          state_next = S_REQ;
          if (kill_q) begin
            kill_next = 1'b0;
            if (redirect_i) pc_next = redirect_target;
          end else if (redirect_i) begin
            pc_next = redirect_target;
          end else if (!stall_i) begin
            load    = 1'b1;
            pc_next = pc_q + PC_STEP;
          end else begin
            // Decode is stalled: park the word so the fetch is not lost.
            skid_pc_next   = pc_q;
            skid_inst_next = imem_rdata_i;
            state_next     = S_HOLD;
          end
        end else if (redirect_i) begin
          kill_next = 1'b1;
          pc_next   = redirect_target;
        end
      end

      S_HOLD: begin
        if (redirect_i) begin
          pc_next    = redirect_target;
          state_next = S_REQ;
        end else if (!stall_i) begin
          load       = 1'b1;
          load_pc    = skid_pc_q;
          load_inst  = skid_inst_q;
          pc_next    = pc_q + PC_STEP;
          state_next = S_REQ;
        end
      end

      default: state_next = S_REQ;
    endcase

    // No request may be presented during the reset cycle.
    if (rst == RST_ENABLE) imem_req_o = 1'b0;
  end

  if_id_reg u_if_id_reg (
    .clk       (clk),
    .rst       (rst),
    .stall     (stall_i),
    .flush     (flush_i),
    .load      (load),
    .load_pc   (load_pc),
    .load_inst (load_inst),
    .id_pc     (id_pc_o),
    .id_inst   (id_inst_o),
    .id_valid  (id_valid_o)
  );

endmodule

// File: tb/tb_if_stage.sv
// -----------------------------------------------------------------------------
// tb_if_stage
// Directed stimulus for if_stage. Expected request addresses and IF/ID
// deliveries are queued as stimulus is issued; a monitor pops and compares
// them whenever the DUT issues a granted request or loads IF/ID.
// A second instance with RESET_PC=32'hFFFF_FFFC covers PC wrap-around.
// -----------------------------------------------------------------------------
module tb_if_stage;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } deliv_t;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        stall = 1'b0, flush = 1'b0, redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        gnt = 1'b0;
  logic        mem_rvalid = 1'b0, stim_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0, stim_rdata = 32'h0;
  int          mem_lat = 1;

  wire         imem_rvalid = mem_rvalid | stim_rvalid;
  wire  [31:0] imem_rdata  = stim_rvalid ? stim_rdata : mem_rdata;

  logic        imem_req, id_valid;
  logic [31:0] imem_addr, id_pc, id_inst;

  // Wrap-around instance signals
  logic        req_w, valid_w;
  logic [31:0] addr_w, pc_w, inst_w;
  logic        rvalid_w = 1'b0;
  logic [31:0] rdata_w = 32'h0;

  int checks = 0;
  int errors = 0;
  int w_nreq = 0;
  int w_ndel = 0;

  logic [31:0] exp_addr[$];
  deliv_t      exp_deliv[$];

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .redirect_i    (redirect),
    .redirect_pc_i (redirect_pc),
    .imem_req_o    (imem_req),
    .imem_addr_o   (imem_addr),
    .imem_gnt_i    (gnt),
    .imem_rvalid_i (imem_rvalid),
    .imem_rdata_i  (imem_rdata),
    .id_pc_o       (id_pc),
    .id_inst_o     (id_inst),
    .id_valid_o    (id_valid)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk           (clk),
    .rst           (rst),
    .stall_i       (1'b0),
    .flush_i       (1'b0),
    .redirect_i    (1'b0),
    .redirect_pc_i (32'h0),
    .imem_req_o    (req_w),
    .imem_addr_o   (addr_w),
    .imem_gnt_i    (1'b1),
    .imem_rvalid_i (rvalid_w),
    .imem_rdata_i  (rdata_w),
    .id_pc_o       (pc_w),
    .id_inst_o     (inst_w),
    .id_valid_o    (valid_w)
  );

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Queue one expected granted request; optionally also its IF/ID delivery.
  task automatic push_fetch(input logic [31:0] a, input bit delivered);
    deliv_t d;
    exp_addr.push_back(a);
    if (delivered) begin
      d.pc   = a;
      d.inst = a ^ 32'hFFFF_FFFF;
      exp_deliv.push_back(d);
    end
  endtask

  // Memory model: response data = address ^ 32'hFFFF_FFFF, mem_lat cycles after gnt.
  initial begin
    bit          fire;
    logic [31:0] fa, pend;
    int          cnt;
    cnt  = 0;
    pend = 32'h0;
    forever begin
      @(negedge clk);
      fire = imem_req && gnt && !rst;
      fa   = imem_addr;
      @(posedge clk);
      #1;
      mem_rvalid = 1'b0;
      if (fire) begin
        pend = fa;
        cnt  = mem_lat;
      end
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata  = pend ^ 32'hFFFF_FFFF;
        end
      end
    end
  end

  // Monitor / scoreboard for the main instance.
  initial begin
    logic   p_rst, p_stall, p_flush;
    deliv_t d;
    logic [31:0] a;
    p_rst = 1'b1; p_stall = 1'b0; p_flush = 1'b0;
    forever begin
      @(negedge clk);
      // IF/ID was free to update at the last edge: valid means a fresh load.
      if (!p_rst && !p_stall && !p_flush) begin
        if (id_valid) begin
          if (exp_deliv.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_delivery actual pc=%h inst=%h required no delivery", id_pc, id_inst);
          end else begin
            d = exp_deliv.pop_front();
            $display("DELIVER pc=%h inst=%h expected pc=%h inst=%h", id_pc, id_inst, d.pc, d.inst);
            check32("deliver_pc", id_pc, d.pc);
            check32("deliver_inst", id_inst, d.inst);
          end
        end else begin
          check32("bubble_inst", id_inst, 32'h0);
        end
      end
      if (imem_req && gnt) begin
        if (exp_addr.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_request actual addr=%h required no request", imem_addr);
        end else begin
          a = exp_addr.pop_front();
          $display("REQUEST addr=%h expected=%h", imem_addr, a);
          check32("req_addr", imem_addr, a);
        end
      end
      p_rst = rst; p_stall = stall; p_flush = flush;
    end
  end

  // Wrap instance: gnt tied high, rvalid one cycle after each grant.
  initial begin
    bit          fw;
    logic [31:0] fwa;
    logic [31:0] w_exp[2];
    w_exp[0] = 32'hFFFF_FFFC;
    w_exp[1] = 32'h0000_0000;
    forever begin
      @(negedge clk);
      if (!rst && valid_w && w_ndel < 2) begin
        $display("WRAP_DELIVER pc=%h inst=%h", pc_w, inst_w);
        check32("wrap_deliver_pc", pc_w, w_exp[w_ndel]);
        check32("wrap_deliver_inst", inst_w, w_exp[w_ndel] ^ 32'hFFFF_FFFF);
        w_ndel++;
      end
      fw  = req_w && !rst;
      fwa = addr_w;
      if (fw && w_nreq < 2) begin
        $display("WRAP_REQUEST addr=%h", addr_w);
        check32("wrap_req_addr", addr_w, w_exp[w_nreq]);
        w_nreq++;
      end
      @(posedge clk);
      #1;
      rvalid_w = fw;
      rdata_w  = fwa ^ 32'hFFFF_FFFF;
    end
  end

  // Stimulus
  initial begin
    // Reset
    tick(3);
    check32("reset_req", {31'h0, imem_req}, 32'h0);
    check32("reset_id_pc", id_pc, 32'h0);
    check32("reset_id_inst", id_inst, 32'h0);
    check32("reset_id_valid", {31'h0, id_valid}, 32'h0);

    // Back-to-back fetches: 0, 4, 8, one delivery every two cycles
    push_fetch(32'h0, 1'b1);
    push_fetch(32'h4, 1'b1);
    push_fetch(32'h8, 1'b1);
    gnt = 1'b1;
    rst = 1'b0;
    tick(6);
    gnt = 1'b0;

    // Stall for 3 cycles while the response to 12 arrives
    push_fetch(32'hC, 1'b1);
    gnt   = 1'b1;
    stall = 1'b1;
    tick(1);
    gnt = 1'b0;
    tick(2);
    check32("stall_hold_pc", id_pc, 32'h8);
    check32("stall_hold_inst", id_inst, 32'hFFFF_FFF7);
    check32("stall_hold_valid", {31'h0, id_valid}, 32'h1);
    check32("hold_no_req", {31'h0, imem_req}, 32'h0);
    stall = 1'b0;
    tick(1);

    // Redirect while waiting; the response to 16 must be discarded
    push_fetch(32'h10, 1'b0);
    push_fetch(32'h100, 1'b1);
    mem_lat = 3;
    gnt     = 1'b1;
    tick(1);
    gnt         = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h103;
    tick(1);
    redirect = 1'b0;
    gnt      = 1'b1;
    mem_lat  = 1;
    check32("wait_no_req", {31'h0, imem_req}, 32'h0);
    tick(3);
    gnt = 1'b0;
    tick(1);

    // Flush together with stall
    stall = 1'b1;
    flush = 1'b1;
    tick(1);
    check32("flush_valid", {31'h0, id_valid}, 32'h0);
    check32("flush_inst", id_inst, 32'h0);
    check32("flush_pc", id_pc, 32'h0);
    stall = 1'b0;
    flush = 1'b0;

    // Redirect in the same cycle the old request is granted
    push_fetch(32'h104, 1'b0);
    push_fetch(32'h200, 1'b1);
    gnt         = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h200;
    tick(1);
    redirect = 1'b0;
    tick(2);
    gnt = 1'b0;
    tick(1);

    // Reset while holding a skid word; a stray rvalid afterwards is ignored
    push_fetch(32'h204, 1'b0);
    gnt   = 1'b1;
    stall = 1'b1;
    tick(1);
    gnt = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check32("rst_hold_req", {31'h0, imem_req}, 32'h0);
    check32("rst_hold_pc", id_pc, 32'h0);
    check32("rst_hold_inst", id_inst, 32'h0);
    check32("rst_hold_valid", {31'h0, id_valid}, 32'h0);
    rst         = 1'b0;
    stall       = 1'b0;
    stim_rvalid = 1'b1;
    stim_rdata  = 32'hDEAD_BEEF;
    tick(1);
    stim_rvalid = 1'b0;
    check32("restart_req", {31'h0, imem_req}, 32'h1);
    check32("restart_addr", imem_addr, 32'h0);
    push_fetch(32'h0, 1'b1);
    gnt = 1'b1;
    tick(1);
    gnt = 1'b0;
    tick(3);

    check32("addr_queue_empty", 32'(exp_addr.size()), 32'h0);
    check32("deliv_queue_empty", 32'(exp_deliv.size()), 32'h0);
    check32("wrap_req_count", 32'(w_nreq), 32'd2);
    check32("wrap_deliv_count", 32'(w_ndel), 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
